conv_window_scheduler: RTL

- Control/sequencing block for the single-window 3x3 convolution datapath.
- Accepts an IFM frame and a kernel as beat streams, and generates write strobes and addresses for the IFM and weight buffers.
- After loading, issues one window base address per accepted handshake in raster order, then signals completion once the datapath pipeline has drained.
- The datapath holds no counters or state of its own; all sequencing lives here.

---
 rtl/conv_window_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/conv_window_scheduler.sv
// -----------------------------------------------------------------------------
// conv_window_scheduler
//
// Sequencer for the single-window KxK convolution datapath. It loads one IFM
// frame and one kernel from beat streams and generates buffer write strobes
// and addresses. It then hands the datapath one window base address per
// accepted handshake, in raster order. Once the datapath pipeline has drained
// it reports completion. All counters and state for the datapath live here.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         IFM pixel beat (contiguous within a frame)
//   weight_valid     kernel weight beat
//   ifm_wr_en/addr   IFM buffer write port (combinational)
//   w_wr_en/addr     weight buffer write port (combinational)
//   win_valid        window base valid, held until win_ready
//   win_ready        datapath accepts the presented window
//   win_base         row*IFM_W+col of the window's top-left pixel
//   last_win         marks the final window of the frame
//   busy             any state other than IDLE
//   done             one-cycle pulse when the frame is complete
//   err              one-cycle pulse when the loaded frame was malformed
// -----------------------------------------------------------------------------
module conv_window_scheduler #(
   parameter int IFM_W    = 7,
   parameter int K        = 3,
   parameter int ADDR_W   = 6,
   parameter int PIPE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              weight_valid,
   output logic              ifm_wr_en,
   output logic [ADDR_W-1:0] ifm_wr_addr,
   output logic              w_wr_en,
   output logic [3:0]        w_wr_addr,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [ADDR_W-1:0] win_base,
   output logic              last_win,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int NPIX     = IFM_W * IFM_W;
   localparam int NWGT     = K * K;
   localparam int LAST_POS = IFM_W - K;
   // icnt must be able to hold NPIX+1 (saturation value flags an over-long frame)
   localparam int CNT_W    = $clog2(NPIX + 2);
   localparam int POS_W    = (IFM_W > 2) ? $clog2(IFM_W) : 1;
   localparam int DCNT_W   = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

   localparam logic [CNT_W-1:0]  NPIX_C     = CNT_W'(NPIX);
   localparam logic [3:0]        NWGT_C     = 4'(NWGT);
   localparam logic [POS_W-1:0]  LAST_POS_C = POS_W'(LAST_POS);
   localparam logic [DCNT_W-1:0] PIPE_LAT_C = DCNT_W'(PIPE_LAT);

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    icnt, icnt_n;
   logic [3:0]          wcnt, wcnt_n;
   logic [POS_W-1:0]    row, row_n, col, col_n;
   logic [DCNT_W-1:0]   dcnt, dcnt_n;
   logic                win_valid_n, last_win_n, busy_n, done_n, err_n;
   logic [ADDR_W-1:0]   win_base_n;
   logic                load_phase;

   // Streams are only accepted while loading; strobes in ISSUE/DRAIN are dropped.
   assign load_phase  = (state == IDLE) || (state == LOAD);
   assign ifm_wr_en   = rst_n && in_valid && load_phase && (icnt < NPIX_C);
   assign ifm_wr_addr = ADDR_W'(icnt);
   assign w_wr_en     = rst_n && weight_valid && load_phase && (wcnt < NWGT_C);
   assign w_wr_addr   = wcnt;

   always_comb begin
      state_n     = state;
      icnt_n      = icnt;
      wcnt_n      = wcnt;
      row_n       = row;
      col_n       = col;
      dcnt_n      = dcnt;
      win_valid_n = win_valid;
      win_base_n  = win_base;
      last_win_n  = last_win;
      done_n      = 1'b0;
      err_n       = 1'b0;

      if (w_wr_en)
         wcnt_n = wcnt + 4'd1;

      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = LOAD;
               icnt_n  = CNT_W'(1);
            end
         end
         LOAD: begin
            if (in_valid) begin
               if (icnt <= NPIX_C)
                  icnt_n = icnt + CNT_W'(1);
            end else if ((icnt == NPIX_C) && (wcnt == NWGT_C)) begin
               // First idle cycle after the frame is the decision point.
               state_n     = ISSUE;
               icnt_n      = '0;
               wcnt_n      = '0;
               row_n       = '0;
               col_n       = '0;
               win_valid_n = 1'b1;
               win_base_n  = '0;
               last_win_n  = (LAST_POS_C == '0);
            end else begin
               state_n = IDLE;
               icnt_n  = '0;
               wcnt_n  = '0;
               err_n   = 1'b1;
            end
         end
         ISSUE: begin
            if (win_valid && win_ready) begin
               if (last_win) begin
                  state_n     = DRAIN;
                  win_valid_n = 1'b0;
                  last_win_n  = 1'b0;
                  dcnt_n      = '0;
               end else begin
                  // Row wrap jumps from (r, IFM_W-K) to (r+1, 0): a step of K.
                  if (col == LAST_POS_C) begin
                     col_n      = '0;
                     row_n      = row + POS_W'(1);
                     win_base_n = win_base + ADDR_W'(K);
                  end else begin
                     col_n      = col + POS_W'(1);
                     win_base_n = win_base + ADDR_W'(1);
                  end
                  last_win_n = (row_n == LAST_POS_C) && (col_n == LAST_POS_C);
               end
            end
         end
         DRAIN: begin
            dcnt_n = dcnt + DCNT_W'(1);
            if (dcnt_n >= PIPE_LAT_C) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         icnt      <= '0;
         wcnt      <= '0;
         row       <= '0;
         col       <= '0;
         dcnt      <= '0;
         win_valid <= 1'b0;
         win_base  <= '0;
         last_win  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         icnt      <= icnt_n;
         wcnt      <= wcnt_n;
         row       <= row_n;
         col       <= col_n;
         dcnt      <= dcnt_n;
         win_valid <= win_valid_n;
         win_base  <= win_base_n;
         last_win  <= last_win_n;
         busy      <= busy_n;
         done      <= done_n;
         err       <= err_n;
      end
   end

endmodule
